data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Parametrised, byte-addressed data memory for the CPU's MEM stage.
//   Generalises the fixed 16-bit, 256-word data memory with:
//   - configurable width and depth
//   - byte and word access, with sign or zero extension on byte loads
//   - misalignment detection
//   - a registered valid/ready handshake
//   - a hardware clear sequencer that zeroes the array after reset or on request
// PARAMETERS
//   DATA_W  16   word width in bits; multiple of 8, >= 16. BYTES = DATA_W/8, BO = log2(BYTES)
//   DEPTH   256  number of words; power of 2. IW = log2(DEPTH)
//   ADDR_W  16   byte-address width; must be >= BO+IW
// PORTS
//   clk         in   1       clock; all state changes on the rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   clear       in   1       synchronous request to re-zero the array (pulse)
//   req_valid   in   1       request present
//   req_ready   out  1       request accepted on an edge where req_valid & req_ready
//   req_write   in   1       1 = store, 0 = load
//   req_byte    in   1       1 = byte access, 0 = full-word access
//   req_signed  in   1       byte load only: 1 = sign-extend, 0 = zero-extend
//   address     in   ADDR_W  byte address
//   writedata   in   DATA_W  store data; a byte store uses writedata[7:0]
//   rsp_valid   out  1       one-cycle response pulse, one per accepted request
//   readdata    out  DATA_W  load result; 0 for stores and for errored accesses
//   rsp_err     out  1       qualifies rsp_valid: access was misaligned
//   init_busy   out  1       clear sequence in progress
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=INIT, clear counter=0
//   - rsp_valid=0, rsp_err=0, readdata=0, init_busy=1, req_ready=0
// - Addressing:
//   - word index = address[BO+IW-1:BO]; bits above BO+IW are ignored (wrap-around)
//   - byte lane = address[BO-1:0]
// - FSM INIT:
//   - writes 0 to word[cnt] each cycle; cnt increments
//   - at cnt==DEPTH-1: writes the last word, then moves to RUN on the same edge
//   - INIT lasts exactly DEPTH cycles; init_busy=1 and req_ready=0 throughout
// - FSM RUN:
//   - req_ready = (state==RUN) & ~clear; combinational
//   - clear=1 in RUN: goes to INIT next edge with cnt=0; a request offered that cycle is not accepted
//   - clear during INIT restarts cnt at 0
// - Accept at edge N: rsp_valid=1 for cycle N+1 only. Fixed latency 1. No back-pressure on responses.
//   One request per cycle; back-to-back accepts give back-to-back responses.
// - Word access: misaligned if address[BO-1:0] != 0
//   - misaligned: no array write; rsp_err=1; readdata=0
// - Byte access: never misaligned.
// - Store:
//   - word store writes the whole word
//   - byte store writes only the addressed lane; other lanes are unchanged
//   - readdata=0 on the response
// - Load:
//   - readdata is the word, or the selected byte extended per req_signed, as of the accept edge
//   - a load accepted the edge after a store to the same word returns the new data
// - rsp_err=0 whenever rsp_valid=0. readdata holds its last value when rsp_valid=0.
// - Reset mid-operation: a pending response is dropped, the sequencer restarts INIT, and array contents are re-zeroed.
// - Unused inputs (req_signed on a store or word access) are ignored.
// TESTING
// (DATA_W=16, DEPTH=256 unless noted)
// - Reset release: init_busy=1 and req_ready=0 for exactly 256 cycles, then req_ready=1.
//   A load of any address returns 0.
// - Word store 0xBEEF @0x0004, then word load @0x0004 -> rsp_valid one cycle after each accept, readdata=0xBEEF, rsp_err=0.
//   Back-to-back store then load also returns 0xBEEF.
// - Byte store 0x80 @0x0005 onto 0xBEEF:
//   - word load -> 0x80EF
//   - signed byte load @0x0005 -> 0xFF80
//   - unsigned byte load -> 0x0080
// - Word store 0x1234 @0x0003 -> rsp_err=1, readdata=0, and word 1 unchanged.
//   Address 0x0204 aliases word 2 (wrap-around).
// - clear pulse mid-stream: req_ready drops the next cycle for 256 cycles; afterwards all loads return 0.
//   Async rst_n low during a load: rsp_valid=0 immediately.
// - Rerun with DATA_W=32, DEPTH=64:
//   - byte store 0xAA @lane 3 of a word holding 0x11223344 -> 0xAA223344
//   - word load @address[1:0]=2 -> rsp_err=1

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed data memory with handshake and clear sequencer
//
// Purpose: MEM-stage data memory. Supports word and byte loads/stores, sign or
// zero extension on byte loads, and misaligned word detection. Responses come
// one cycle after a request is accepted. A sequencer zeroes every word after
// reset or on a clear request.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   clear      : request to re-zero the array (pulse)
//   req_valid  : request present
//   req_ready  : request accepted when req_valid & req_ready at a rising edge
//   req_write  : 1 = store, 0 = load
//   req_byte   : 1 = byte access, 0 = word access
//   req_signed : byte load extension select (1 = sign, 0 = zero)
//   address    : byte address
//   writedata  : store data; byte stores use writedata[7:0]
//   rsp_valid  : one-cycle response pulse per accepted request
//   readdata   : load result; 0 for stores and errored accesses
//   rsp_err    : response was a misaligned word access
//   init_busy  : clear sequence in progress
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] readdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int BO    = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IW-1:0]     idx;
  logic [BO-1:0]     lane;
  logic              accept;
  logic              misaligned;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [DATA_W-1:0] load_data;
  logic              unused_addr;

  // Address bits above the word index are ignored, so the array wraps.
  assign idx         = address[BO+IW-1:BO];
  assign lane        = address[BO-1:0];
  assign unused_addr = ^address;

  assign req_ready  = (state_q == ST_RUN) & ~clear;
  assign init_busy  = (state_q == ST_INIT);
  assign accept     = req_valid & req_ready;
  assign misaligned = ~req_byte & (lane != '0);

  // Reading the array before the edge gives the contents as of the accept
  // edge; a store on the previous edge is already visible here.
  assign rd_word   = mem_q[idx];
  assign rd_byte   = rd_word[{lane, 3'b000} +: 8];
  assign load_data = req_byte ? {{(DATA_W-8){req_signed & rd_byte[7]}}, rd_byte}
                              : rd_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = accept;
    rsp_err_d   = accept & misaligned;
    readdata_d  = readdata_q;

    case (state_q)
      ST_INIT: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase

    if (accept) begin
      readdata_d = (misaligned | req_write) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      readdata_q  <= readdata_d;
    end
  end

  // The array has no reset; the INIT sequence is what zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (accept & req_write & ~misaligned) begin
      if (req_byte) begin
        mem_q[idx][{lane, 3'b000} +: 8] <= writedata[7:0];
      end else begin
        mem_q[idx] <= writedata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;

  logic        clear;
  logic        req_valid, req_ready, req_write, req_byte, req_signed;
  logic [15:0] address, writedata, readdata;
  logic        rsp_valid, rsp_err, init_busy;

  logic        clear32;
  logic        req_valid32, req_ready32, req_write32, req_byte32, req_signed32;
  logic [15:0] address32;
  logic [31:0] writedata32, readdata32;
  logic        rsp_valid32, rsp_err32, init_busy32;

  int tests;
  int fails;

  data_mem_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .address(address),
    .writedata(writedata), .rsp_valid(rsp_valid), .readdata(readdata),
    .rsp_err(rsp_err), .init_busy(init_busy)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear32),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_write(req_write32),
    .req_byte(req_byte32), .req_signed(req_signed32), .address(address32),
    .writedata(writedata32), .rsp_valid(rsp_valid32), .readdata(readdata32),
    .rsp_err(rsp_err32), .init_busy(init_busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on the 16-bit instance: drive at a falling edge, accepted on
  // the next rising edge, response sampled at the following falling edge.
  task automatic req16(input logic wr, input logic by, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wd,
                       output logic v, output logic e, output logic [15:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_byte = by; req_signed = sg;
    address = addr; writedata = wd;
    @(negedge clk);
    v = rsp_valid; e = rsp_err; rd = readdata;
    req_valid = 1'b0;
  endtask

  task automatic req32(input logic wr, input logic by, input logic sg,
                       input logic [15:0] addr, input logic [31:0] wd,
                       output logic v, output logic e, output logic [31:0] rd);
    @(negedge clk);
    req_valid32 = 1'b1; req_write32 = wr; req_byte32 = by; req_signed32 = sg;
    address32 = addr; writedata32 = wd;
    @(negedge clk);
    v = rsp_valid32; e = rsp_err32; rd = readdata32;
    req_valid32 = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic v, e;
    logic [15:0] rd;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0000; addrs[1] = 16'h01FE; addrs[2] = 16'h00AA;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    tests++; if (readdata !== 16'h0000) begin fails++; $display("FAIL reset_readdata got %h want 0000", readdata); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_init_busy got %b want 1", init_busy); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    rst_n = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); n++; @(negedge clk);
      if (n < 256 && init_busy !== 1'b1) begin
        tests++; fails++; $display("FAIL reset_busy_early got %b want 1 at cycle %0d", init_busy, n);
      end
    end
    tests++; if (n !== 256) begin fails++; $display("FAIL reset_init_cycles got %0d want 256", n); end
    tests++; if (init_busy !== 1'b0) begin fails++; $display("FAIL reset_busy_end got %b want 0", init_busy); end
    for (int i = 0; i < 3; i++) begin
      req16(1'b0, 1'b0, 1'b0, addrs[i], 16'h0, v, e, rd);
      tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 16'h0000) begin
        fails++; $display("FAIL reset_load_zero addr %h got v=%b e=%b rd=%h want v=1 e=0 rd=0000", addrs[i], v, e, rd);
      end
    end
  endtask

  task automatic test_word();
    logic v, e;
    logic [15:0] rd;
    req16(1'b1, 1'b0, 1'b0, 16'h0004, 16'hBEEF, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 16'h0000) begin
      fails++; $display("FAIL word_store_rsp got v=%b e=%b rd=%h want v=1 e=0 rd=0000", v, e, rd);
    end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL word_rsp_one_cycle got %b want 0", rsp_valid); end
    req16(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 16'hBEEF) begin
      fails++; $display("FAIL word_load got v=%b e=%b rd=%h want v=1 e=0 rd=beef", v, e, rd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    address = 16'h0008; writedata = 16'hBEEF;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || readdata !== 16'h0000) begin
      fails++; $display("FAIL b2b_store_rsp got v=%b rd=%h want v=1 rd=0000", rsp_valid, readdata);
    end
    req_write = 1'b0; writedata = 16'h0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || readdata !== 16'hBEEF) begin
      fails++; $display("FAIL b2b_load got v=%b e=%b rd=%h want v=1 e=0 rd=beef", rsp_valid, rsp_err, readdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || readdata !== 16'hBEEF) begin
      fails++; $display("FAIL b2b_idle_hold got v=%b rd=%h want v=0 rd=beef", rsp_valid, readdata);
    end
  endtask

  task automatic test_byte();
    logic v, e;
    logic [15:0] rd;
    req16(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1280, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 16'h0000) begin
      fails++; $display("FAIL byte_store_rsp got v=%b e=%b rd=%h want v=1 e=0 rd=0000", v, e, rd);
    end
    req16(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, v, e, rd);
    tests++; if (rd !== 16'h80EF) begin fails++; $display("FAIL byte_word_load got %h want 80ef", rd); end
    req16(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 16'hFF80) begin
      fails++; $display("FAIL byte_signed_hi got v=%b e=%b rd=%h want v=1 e=0 rd=ff80", v, e, rd);
    end
    req16(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, v, e, rd);
    tests++; if (rd !== 16'h0080) begin fails++; $display("FAIL byte_unsigned_hi got %h want 0080", rd); end
    req16(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0, v, e, rd);
    tests++; if (rd !== 16'hFFEF) begin fails++; $display("FAIL byte_signed_lo got %h want ffef", rd); end
    req16(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, v, e, rd);
    tests++; if (rd !== 16'h00EF) begin fails++; $display("FAIL byte_unsigned_lo got %h want 00ef", rd); end
  endtask

  task automatic test_misalign();
    logic v, e;
    logic [15:0] rd;
    req16(1'b1, 1'b0, 1'b0, 16'h0002, 16'h5A5A, v, e, rd);
    req16(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0, v, e, rd);
    tests++; if (rd !== 16'h5A5A) begin fails++; $display("FAIL mis_preload got %h want 5a5a", rd); end
    req16(1'b1, 1'b0, 1'b0, 16'h0003, 16'h1234, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b1 || rd !== 16'h0000) begin
      fails++; $display("FAIL mis_store got v=%b e=%b rd=%h want v=1 e=1 rd=0000", v, e, rd);
    end
    @(negedge clk);
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL mis_err_idle got %b want 0", rsp_err); end
    req16(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0, v, e, rd);
    tests++; if (e !== 1'b0 || rd !== 16'h5A5A) begin
      fails++; $display("FAIL mis_unchanged got e=%b rd=%h want e=0 rd=5a5a", e, rd);
    end
    req16(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, v, e, rd);
    tests++; if (e !== 1'b1 || rd !== 16'h0000) begin
      fails++; $display("FAIL mis_load got e=%b rd=%h want e=1 rd=0000", e, rd);
    end
    req16(1'b1, 1'b0, 1'b0, 16'h0204, 16'hCAFE, v, e, rd);
    req16(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, v, e, rd);
    tests++; if (e !== 1'b0 || rd !== 16'hCAFE) begin
      fails++; $display("FAIL alias_wrap got e=%b rd=%h want e=0 rd=cafe", e, rd);
    end
  endtask

  task automatic test_clear();
    int n;
    logic v, e;
    logic [15:0] rd;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0004; addrs[1] = 16'h0010; addrs[2] = 16'h0002;
    @(negedge clk);
    clear = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    address = 16'h0010; writedata = 16'hFFFF;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL clear_ready_comb got %b want 0", req_ready); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || init_busy !== 1'b1) begin
      fails++; $display("FAIL clear_no_accept got v=%b busy=%b want v=0 busy=1", rsp_valid, init_busy);
    end
    clear = 1'b0; req_valid = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); n++; @(negedge clk);
    end
    tests++; if (n !== 256) begin fails++; $display("FAIL clear_cycles got %0d want 256", n); end
    for (int i = 0; i < 3; i++) begin
      req16(1'b0, 1'b0, 1'b0, addrs[i], 16'h0, v, e, rd);
      tests++; if (v !== 1'b1 || rd !== 16'h0000) begin
        fails++; $display("FAIL clear_zero addr %h got v=%b rd=%h want v=1 rd=0000", addrs[i], v, rd);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic v, e;
    logic [15:0] rd;
    req16(1'b1, 1'b0, 1'b0, 16'h0004, 16'h7777, v, e, rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; address = 16'h0004;
    @(posedge clk);
    #1;
    tests++; if (rsp_valid !== 1'b1 || readdata !== 16'h7777) begin
      fails++; $display("FAIL arst_pre got v=%b rd=%h want v=1 rd=7777", rsp_valid, readdata);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || readdata !== 16'h0000 || req_ready !== 1'b0) begin
      fails++; $display("FAIL arst_drop got v=%b rd=%h rdy=%b want v=0 rd=0000 rdy=0", rsp_valid, readdata, req_ready);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); n++; @(negedge clk);
    end
    tests++; if (n !== 256) begin fails++; $display("FAIL arst_init_cycles got %0d want 256", n); end
    req16(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, v, e, rd);
    tests++; if (v !== 1'b1 || rd !== 16'h0000) begin
      fails++; $display("FAIL arst_rezero got v=%b rd=%h want v=1 rd=0000", v, rd);
    end
  endtask

  task automatic test_wide();
    int n;
    logic v, e;
    logic [31:0] rd;
    n = 0;
    while (req_ready32 !== 1'b1 && n < 1000) begin
      @(negedge clk); n++;
    end
    tests++; if (req_ready32 !== 1'b1) begin fails++; $display("FAIL w32_ready got %b want 1", req_ready32); end
    req32(1'b1, 1'b0, 1'b0, 16'h0008, 32'h11223344, v, e, rd);
    req32(1'b1, 1'b1, 1'b0, 16'h000B, 32'hDEADBEAA, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL w32_byte_store got v=%b e=%b rd=%h want v=1 e=0 rd=0", v, e, rd);
    end
    req32(1'b0, 1'b0, 1'b0, 16'h0008, 32'h0, v, e, rd);
    tests++; if (rd !== 32'hAA223344) begin fails++; $display("FAIL w32_lane3 got %h want aa223344", rd); end
    req32(1'b0, 1'b0, 1'b0, 16'h000A, 32'h0, v, e, rd);
    tests++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL w32_misalign got v=%b e=%b rd=%h want v=1 e=1 rd=0", v, e, rd);
    end
    req32(1'b0, 1'b1, 1'b1, 16'h000B, 32'h0, v, e, rd);
    tests++; if (rd !== 32'hFFFFFFAA) begin fails++; $display("FAIL w32_signed_byte got %h want ffffffaa", rd); end
    req32(1'b0, 1'b1, 1'b0, 16'h0009, 32'h0, v, e, rd);
    tests++; if (rd !== 32'h00000033) begin fails++; $display("FAIL w32_unsigned_byte got %h want 00000033", rd); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    clear = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; address = '0; writedata = '0;
    clear32 = 1'b0; req_valid32 = 1'b0; req_write32 = 1'b0; req_byte32 = 1'b0;
    req_signed32 = 1'b0; address32 = '0; writedata32 = '0;
    test_reset();
    test_word();
    test_back_to_back();
    test_byte();
    test_misalign();
    test_clear();
    test_async_reset();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
